// File: rtl/rs232_uart.sv
// 8N1 RS-232 byte transport: a request/strobe driven transmitter and a
// mid-bit sampling receiver sharing one clock. CLKS_PER_BIT must be >= 4.
module rs232_uart #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       INIT,
  input  logic       DRL,
  input  logic [7:0] DIN,
  output logic       LOAD,
  output logic       TX,
  input  logic       RX,
  output logic [7:0] DOUT,
  output logic       STORE
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_REQ, TX_FETCH, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  tx_state_t          tx_state_q, tx_state_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]         tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic               tx_q, tx_d;

  rx_state_t          rx_state_q, rx_state_d;
  logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]         rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               store_q, store_d;
  logic               rx_meta_q, rx_meta_d;
  logic               rx_s_q, rx_s_d;

  assign LOAD  = (tx_state_q == TX_REQ);
  assign TX    = tx_q;
  assign DOUT  = dout_q;
  assign STORE = store_q;

  // Transmit path: the user answers LOAD by presenting DIN during FETCH.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d     = 1'b1;
        tx_cnt_d = '0;
        if (DRL) tx_state_d = TX_REQ;
      end
      TX_REQ: tx_state_d = TX_FETCH;
      TX_FETCH: begin
        tx_shift_d = DIN;
        tx_d       = 1'b0;
        tx_cnt_d   = '0;
        tx_state_d = TX_START;
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
    end
  end

  always_ff @(posedge CLK) begin
    tx_shift_q <= tx_shift_d;
  end

  // Receive path: two-flop synchronizer, then half-bit alignment on the start bit.
  always_comb begin
    rx_meta_d  = RX;
    rx_s_d     = rx_meta_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    dout_d     = dout_q;
    store_d    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[DATA_W-1:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          // A low stop bit is a framing error: the byte is dropped silently.
          if (rx_s_q) begin
            dout_d  = rx_shift_q;
            store_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      dout_q     <= '0;
      store_q    <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      dout_q     <= dout_d;
      store_q    <= store_d;
    end
  end

  always_ff @(posedge CLK) begin
    rx_shift_q <= rx_shift_d;
  end

endmodule

// File: tb/tb_rs232_uart.sv
// Directed bench for rs232_uart with CLKS_PER_BIT=16: TX looped to RX by default,
// RX hand-driven for glitch and framing cases; received bytes checked against a queue.
module tb_rs232_uart;

  localparam int CPB = 16;

  logic       CLK;
  logic       INIT;
  logic       DRL;
  logic [7:0] DIN;
  logic       LOAD;
  logic       TX;
  logic [7:0] DOUT;
  logic       STORE;
  logic       rx_manual;
  logic       rx_drv;
  logic       rx_line;

  int n_assert;
  int n_fail;
  int load_cnt;
  int store_cnt;
  logic [7:0] exp_q[$];

  assign rx_line = rx_manual ? rx_drv : TX;

  rs232_uart #(.CLKS_PER_BIT(CPB)) dut (
    .CLK   (CLK),
    .INIT  (INIT),
    .DRL   (DRL),
    .DIN   (DIN),
    .LOAD  (LOAD),
    .TX    (TX),
    .RX    (rx_line),
    .DOUT  (DOUT),
    .STORE (STORE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_load(input string tag);
    int n = 0;
    while (LOAD !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    check(tag, 32'(LOAD), 32'd1);
  endtask

  task automatic wait_tx_low(input string tag);
    int n = 0;
    while (TX !== 1'b0 && n < 10) begin
      tick(1);
      n++;
    end
    check(tag, 32'(TX), 32'd0);
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    rx_drv = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = data[i];
      tick(CPB);
    end
    rx_drv = stop_bit;
    tick(CPB);
    rx_drv = 1'b1;
  endtask

  // Scoreboard: every STORE must match the oldest expected byte.
  always @(negedge CLK) begin
    if (LOAD === 1'b1) load_cnt++;
    if (STORE === 1'b1) begin
      store_cnt++;
      if (exp_q.size() == 0) begin
        check("store_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("store_dout", 32'(DOUT), 32'(e));
      end
    end
  end

  initial begin
    logic [9:0] frame;
    logic [7:0] stream [6];
    int lc0;
    int sc0;

    n_assert  = 0;
    n_fail    = 0;
    load_cnt  = 0;
    store_cnt = 0;
    INIT      = 1'b1;
    DRL       = 1'b0;
    DIN       = 8'h00;
    rx_manual = 1'b0;
    rx_drv    = 1'b1;
    stream    = '{8'h06, 8'h14, 8'h55, 8'h00, 8'hFF, 8'h07};

    tick(2);
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_load", 32'(LOAD), 32'd0);
    check("rst_store", 32'(STORE), 32'd0);
    check("rst_dout", 32'(DOUT), 32'h00);
    INIT = 1'b0;
    tick(5);
    check("idle_tx", 32'(TX), 32'd1);

    // Single byte, DRL dropped right after LOAD.
    lc0 = load_cnt;
    sc0 = store_cnt;
    DRL = 1'b1;
    wait_load("single_load");
    DIN = 8'h05;
    DRL = 1'b0;
    exp_q.push_back(8'h05);
    wait_tx_low("single_tx_fall");
    frame = {1'b1, 8'h05, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      check("single_tx_bit", 32'(TX), 32'(frame[i / CPB]));
      tick(1);
    end
    tick(40);
    check("single_loads", 32'(load_cnt - lc0), 32'd1);
    check("single_stores", 32'(store_cnt - sc0), 32'd1);
    check("single_dout", 32'(DOUT), 32'h05);
    check("single_tx_idle", 32'(TX), 32'd1);

    // Back-to-back stream with DRL held high.
    lc0 = load_cnt;
    sc0 = store_cnt;
    DRL = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_load("stream_load");
      DIN = stream[k];
      exp_q.push_back(stream[k]);
      if (k == 5) DRL = 1'b0;
      tick(1);
    end
    wait_drain("stream_drain", 600);
    tick(30);
    check("stream_loads", 32'(load_cnt - lc0), 32'd6);
    check("stream_stores", 32'(store_cnt - sc0), 32'd6);
    check("stream_dout", 32'(DOUT), 32'h07);
    check("stream_tx_idle", 32'(TX), 32'd1);
    tick(100);
    check("stream_no_more_loads", 32'(load_cnt - lc0), 32'd6);
    check("stream_tx_still_idle", 32'(TX), 32'd1);

    // Short low pulse on RX must be rejected, then a real byte accepted.
    rx_manual = 1'b1;
    rx_drv    = 1'b1;
    tick(5);
    sc0 = store_cnt;
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(40);
    check("glitch_no_store", 32'(store_cnt - sc0), 32'd0);
    exp_q.push_back(8'hA3);
    send_byte(8'hA3, 1'b1);
    tick(20);
    check("glitch_next_store", 32'(store_cnt - sc0), 32'd1);
    check("glitch_next_dout", 32'(DOUT), 32'hA3);

    // Low stop bit: framing error, DOUT must hold its previous value.
    tick(20);
    sc0 = store_cnt;
    send_byte(8'h3C, 1'b0);
    tick(40);
    check("frame_err_no_store", 32'(store_cnt - sc0), 32'd0);
    check("frame_err_dout_held", 32'(DOUT), 32'hA3);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    tick(20);
    check("frame_ok_store", 32'(store_cnt - sc0), 32'd1);
    check("frame_ok_dout", 32'(DOUT), 32'h3C);

    // INIT during data bit 4 of both TX and RX.
    rx_manual = 1'b0;
    tick(10);
    lc0 = load_cnt;
    sc0 = store_cnt;
    DRL = 1'b1;
    wait_load("midrst_load");
    DIN = 8'h81;
    DRL = 1'b0;
    wait_tx_low("midrst_tx_fall");
    tick(5 * CPB + 8);
    INIT = 1'b1;
    tick(1);
    check("midrst_tx", 32'(TX), 32'd1);
    check("midrst_load", 32'(LOAD), 32'd0);
    check("midrst_store", 32'(STORE), 32'd0);
    tick(1);
    INIT = 1'b0;
    check("midrst_dout", 32'(DOUT), 32'h00);
    tick(200);
    check("midrst_no_store", 32'(store_cnt - sc0), 32'd0);
    check("midrst_tx_idle", 32'(TX), 32'd1);
    DRL = 1'b1;
    wait_load("after_rst_load");
    DIN = 8'h81;
    DRL = 1'b0;
    exp_q.push_back(8'h81);
    wait_drain("after_rst_drain", 400);
    tick(10);
    check("after_rst_dout", 32'(DOUT), 32'h81);
    check("after_rst_stores", 32'(store_cnt - sc0), 32'd1);
    check("after_rst_loads", 32'(load_cnt - lc0), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
